eight_to_three_rr_encoder: RTL and testbench
============================================

Name: eight_to_three_rr_encoder

Overview:
- Registered 8-to-3 encoder with round-robin arbitration. It is the inverse of the register-file write-select decoder.
- Collects up to eight request lines (ALU result sources, forwarding paths) into a pending set. Emits one 3-bit source index at a time over a valid/ready handshake to the write-back stage.
- Guarantees fairness: no requester is starved while others are continuously active.

Parameters:
- FIXED_PRIORITY, 0, 1 = always pick lowest-numbered pending bit (pointer ignored); 0 = round-robin from pointer.
- RESET_PTR, 0, pointer value after reset (0..7).

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- req_in  input  8  request pulses/levels; bit i high for one or more cycles sets pending[i].
- enable  input  1  grant enable; low = capture requests but issue no new codes.
- code_out  output  3  encoded index of granted requester.
- code_valid  output  1  code_out holds a valid grant.
- code_ready  input  1  consumer accepts code_out this cycle.
- pending_out  output  8  current pending register (debug/observability).
- busy  output  1  high when pending_out != 0 or code_valid == 1.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - pending = 0, code_valid = 0, code_out = 0, pointer = RESET_PTR, busy = 0.
  - A reset mid-handshake drops the grant; the consumer must ignore the lost code.
- Candidate set each cycle: cand = (pending | req_in) & ~held_bit.
  - held_bit is the one-hot of code_out while code_valid = 1, else 0.
- Two states:
  - IDLE (code_valid = 0): if enable & (cand != 0), next edge loads code_out = selected index and code_valid = 1 (HOLD). Otherwise stay IDLE; pending |= req_in.
  - HOLD (code_valid = 1): code_out and code_valid stay stable until code_ready = 1.
    - On accept edge: clear pending[code_out], unless req_in[code_out] = 1 that same cycle (set wins; the bit stays pending).
    - Pointer = (code_out + 1) mod 8.
    - If enable & (cand != 0): load the next code on the same edge, staying in HOLD (back-to-back; one grant per cycle). Otherwise go to IDLE.
- Latency: req_in high at edge N, idle, enable = 1 → code_valid at edge N+1. Throughput is one code per cycle with code_ready tied high.
- Selection:
  - Round-robin: first set bit of cand scanning pointer, pointer+1, ... wrapping 7→0.
  - FIXED_PRIORITY = 1: lowest set bit.
- Pending bits:
  - A granted bit stays set in pending until accepted.
  - Repeated req_in on an already-pending bit merges; no queue depth per requester.
- enable:
  - enable = 0 in HOLD does not withdraw the current code; it only blocks the follow-on grant.
  - enable = 0 in IDLE: requests accumulate.
- Pointer updates only on accept, never on grant.
- code_out is held at its last value while IDLE. Consumers qualify it with code_valid.
- busy is combinational from the registers.

Optional Feature:
- Macro ENCODER_MERGE_CNT_EN.
- Defined:
  - Adds output merge_cnt [7:0], reset 0.
  - Increments by the number of bits in req_in & pending each cycle, i.e. requests merged into an already-pending bit, including the set-wins accept case.
  - Saturates at 255. Cleared only by reset.
- Undefined: port and logic absent; the rest of the behaviour is identical.

Decomposition:
- Shared package alu_ctrl_pkg:
  - typedef src_idx_t (logic [2:0]).
  - typedef src_vec_t (logic [7:0]).
  - localparam NUM_SRC = 8.
  - Function onehot3 (3-bit to 8-bit one-hot), shared with the decoder side.
- One sub-module: rr_pick8.
  - Purely combinational.
  - Inputs: cand, pointer, FIXED_PRIORITY.
  - Outputs: found, idx.
  - Implemented as a double-width rotate plus lowest-set-bit scan.
- The top holds pending, pointer, the HOLD/IDLE flag and output registers.

Test Plan:
- After reset, pulse req_in = 8'b0010_0000 one cycle, enable = 1, code_ready = 1 → code_valid at next edge with code_out = 5; pending clears on accept; busy falls the cycle after.
- req_in = 8'hFF held, code_ready = 1, RESET_PTR = 0 → codes 0,1,2,...,7,0 on consecutive cycles. With FIXED_PRIORITY = 1 → code stays 0 every cycle.
- code_ready = 0 for 5 cycles with code_out = 3 while req_in toggles bits 1 and 6 → code_out/code_valid stable. After ready: accept 3, next code = 6 (pointer 4 scan), then 1.
- enable = 0, pulse req_in bits 2 and 4 → code_valid stays 0 and pending_out = 8'h14. Raise enable → codes 2 then 4.
- Accept edge for code 2 with req_in[2] = 1 the same cycle → pending_out[2] remains 1; code 2 is re-granted after the other pending bits in round-robin order. With ENCODER_MERGE_CNT_EN defined, merge_cnt increments by 1.
- Assert reset_n = 0 mid-HOLD, asynchronously between edges → code_valid, pending_out and busy go to 0 immediately, before the next clk edge; the pointer returns to RESET_PTR.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared source-index types and helpers for the ALU write-back select path
package alu_ctrl_pkg;

    localparam int NUM_SRC = 8;

    typedef logic [2:0] src_idx_t;
    typedef logic [7:0] src_vec_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } enc_state_t;

    // 3-bit index to 8-bit one-hot, same mapping as the write-select decoder
    function automatic src_vec_t onehot3(input src_idx_t idx);
        onehot3 = src_vec_t'(1) << idx;
    endfunction

    // Number of set bits in a source vector
    function automatic logic [3:0] popcount8(input src_vec_t vec);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cnt = cnt + {3'd0, vec[i]};
        end
        popcount8 = cnt;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational round-robin / fixed-priority pick of one of eight candidates
module rr_pick8
    import alu_ctrl_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic [7:0] cand,
    input  logic [2:0] pointer,
    output logic       found,
    output logic [2:0] idx
);

    src_idx_t        base;
    logic     [15:0] dbl;
    src_vec_t        rot;
    src_idx_t        offset;

    // Rotate candidates so the pointer position lands at bit 0, then take the lowest set bit
    always_comb begin
        base   = (FIXED_PRIORITY != 0) ? 3'd0 : pointer;
        dbl    = {cand, cand};
        rot    = 8'(dbl >> base);
        offset = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = i[2:0];
            end
        end
        found = |cand;
        idx   = base + offset;
    end

endmodule

// File: rtl/eight_to_three_rr_encoder.sv
// rtl/eight_to_three_rr_encoder.sv - registered 8-to-3 round-robin encoder with valid/ready output (option: ENCODER_MERGE_CNT_EN)
module eight_to_three_rr_encoder
    import alu_ctrl_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0,
    parameter int RESET_PTR      = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] req_in,
    input  logic       enable,
    output logic [2:0] code_out,
    output logic       code_valid,
    input  logic       code_ready,
    output logic [7:0] pending_out,
`ifdef ENCODER_MERGE_CNT_EN
    output logic [7:0] merge_cnt,
`endif
    output logic       busy
);

    enc_state_t state;
    enc_state_t state_next;
    src_vec_t   pending;
    src_vec_t   pending_next;
    src_idx_t   pointer;
    src_idx_t   pointer_next;
    src_idx_t   code_reg;
    src_idx_t   code_next;

    src_vec_t   held;
    src_vec_t   cand;
    src_idx_t   scan_ptr;
    src_idx_t   pick_idx;
    logic       pick_found;
    logic       accept;
    logic       load;

    // Candidate set, handshake decode and the grant/accept qualifiers
    always_comb begin
        held     = (state == ST_HOLD) ? onehot3(code_reg) : '0;
        cand     = (pending | req_in) & ~held;
        accept   = (state == ST_HOLD) && code_ready;
        // A back-to-back grant on the accept edge scans from the freshly advanced pointer
        scan_ptr = accept ? (code_reg + 3'd1) : pointer;
        load     = enable && pick_found && ((state == ST_IDLE) || accept);
    end

    rr_pick8 #(
        .FIXED_PRIORITY(FIXED_PRIORITY)
    ) u_pick (
        .cand   (cand),
        .pointer(scan_ptr),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: IDLE grants when possible, HOLD leaves only on accept without a follow-on grant
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (accept && !load) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath next values: pending merge/clear (set wins), pointer advance on accept, code load
    always_comb begin
        pending_next = pending | req_in;
        if (accept) begin
            pending_next = pending_next & ~(held & ~req_in);
        end
        pointer_next = accept ? (code_reg + 3'd1) : pointer;
        code_next    = load ? pick_idx : code_reg;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= '0;
            pointer  <= src_idx_t'(RESET_PTR);
            code_reg <= '0;
        end else begin
            pending  <= pending_next;
            pointer  <= pointer_next;
            code_reg <= code_next;
        end
    end

    // FSM outputs and observability, all straight from registers
    always_comb begin
        code_valid  = (state == ST_HOLD);
        code_out    = code_reg;
        pending_out = pending;
        busy        = (|pending) || (state == ST_HOLD);
    end

`ifdef ENCODER_MERGE_CNT_EN
    logic [8:0] merge_sum;

    // Sum of requests landing on already-pending bits this cycle
    always_comb begin
        merge_sum = {1'b0, merge_cnt} + {5'd0, popcount8(req_in & pending)};
    end

    // Saturating merge counter, cleared only by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            merge_cnt <= 8'd0;
        end else if (merge_sum[8]) begin
            merge_cnt <= 8'hFF;
        end else begin
            merge_cnt <= merge_sum[7:0];
        end
    end
`endif

endmodule

// File: tb/tb_eight_to_three_rr_encoder.sv
// tb/tb_eight_to_three_rr_encoder.sv - directed self-checking bench for eight_to_three_rr_encoder
module tb_eight_to_three_rr_encoder;

    logic       clk;
    logic       reset_n;
    logic [7:0] req_in;
    logic       enable;
    logic [2:0] code_out;
    logic       code_valid;
    logic       code_ready;
    logic [7:0] pending_out;
    logic       busy;
`ifdef ENCODER_MERGE_CNT_EN
    logic [7:0] merge_cnt;
`endif

    int checks;
    int failures;

    eight_to_three_rr_encoder #(
        .FIXED_PRIORITY(0),
        .RESET_PTR     (0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_in     (req_in),
        .enable     (enable),
        .code_out   (code_out),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .pending_out(pending_out),
`ifdef ENCODER_MERGE_CNT_EN
        .merge_cnt  (merge_cnt),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_in  = 8'h00;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset_n    = 1'b0;
        req_in     = 8'h00;
        enable     = 1'b0;
        code_ready = 1'b0;

        // Reset state
        step();
        step();
        check("rst_valid", {31'd0, code_valid}, 32'd0);
        check("rst_code", {29'd0, code_out}, 32'd0);
        check("rst_pending", {24'd0, pending_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;

        // Single pulse on bit 5: grant next edge, accept, go idle
        enable     = 1'b1;
        code_ready = 1'b1;
        req_in     = 8'h20;
        step();
        check("t1_valid", {31'd0, code_valid}, 32'd1);
        check("t1_code", {29'd0, code_out}, 32'd5);
        check("t1_pending", {24'd0, pending_out}, 32'h20);
        check("t1_busy", {31'd0, busy}, 32'd1);
        req_in = 8'h00;
        step();
        check("t1_valid_off", {31'd0, code_valid}, 32'd0);
        check("t1_pending_clr", {24'd0, pending_out}, 32'h00);
        check("t1_busy_off", {31'd0, busy}, 32'd0);

        // All requests held: codes 0..7 then 0, one per cycle
        do_reset();
        req_in = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("t2_code%0d", i), {29'd0, code_out}, i % 8);
            check($sformatf("t2_valid%0d", i), {31'd0, code_valid}, 32'd1);
        end

        // Back-pressure: code 3 held stable while bits 1 and 6 toggle
        do_reset();
        code_ready = 1'b0;
        req_in     = 8'h08;
        step();
        check("t3_code3", {29'd0, code_out}, 32'd3);
        for (int i = 0; i < 5; i++) begin
            req_in = (i % 2 == 0) ? 8'h02 : 8'h40;
            step();
            check($sformatf("t3_hold_code%0d", i), {29'd0, code_out}, 32'd3);
            check($sformatf("t3_hold_valid%0d", i), {31'd0, code_valid}, 32'd1);
        end
        check("t3_pending", {24'd0, pending_out}, 32'h4A);
        req_in     = 8'h00;
        code_ready = 1'b1;
        step();
        check("t3_next6", {29'd0, code_out}, 32'd6);
        step();
        check("t3_next1", {29'd0, code_out}, 32'd1);
        step();
        check("t3_idle", {31'd0, code_valid}, 32'd0);
        check("t3_busy", {31'd0, busy}, 32'd0);

        // Enable low: requests accumulate, then drain in round-robin order
        do_reset();
        enable = 1'b0;
        req_in = 8'h14;
        step();
        req_in = 8'h00;
        step();
        check("t4_valid_blocked", {31'd0, code_valid}, 32'd0);
        check("t4_pending", {24'd0, pending_out}, 32'h14);
        enable = 1'b1;
        step();
        check("t4_code2", {29'd0, code_out}, 32'd2);
        check("t4_valid2", {31'd0, code_valid}, 32'd1);
        step();
        check("t4_code4", {29'd0, code_out}, 32'd4);
        step();
        check("t4_done", {31'd0, code_valid}, 32'd0);
        check("t4_pending_clr", {24'd0, pending_out}, 32'h00);

        // Set wins on accept: bit 2 re-requested on its own accept edge
        do_reset();
        req_in = 8'h54;
        step();
        check("t5_code2", {29'd0, code_out}, 32'd2);
        req_in = 8'h04;
        step();
        check("t5_code4", {29'd0, code_out}, 32'd4);
        check("t5_pending_kept", {24'd0, pending_out}, 32'h54);
        req_in = 8'h00;
        step();
        check("t5_code6", {29'd0, code_out}, 32'd6);
        step();
        check("t5_code2_again", {29'd0, code_out}, 32'd2);
        check("t5_pending_2", {24'd0, pending_out}, 32'h04);
        step();
        check("t5_idle", {31'd0, code_valid}, 32'd0);
        check("t5_pending_clr", {24'd0, pending_out}, 32'h00);
`ifdef ENCODER_MERGE_CNT_EN
        check("t5_merge_cnt", {24'd0, merge_cnt}, 32'd1);
`endif

        // Asynchronous reset mid-HOLD; pointer must return to 0
        do_reset();
        req_in = 8'h20;
        step();
        req_in = 8'h00;
        step();
        code_ready = 1'b0;
        req_in     = 8'h82;
        step();
        check("t6_pre_code7", {29'd0, code_out}, 32'd7);
        req_in = 8'h00;
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_valid", {31'd0, code_valid}, 32'd0);
        check("t6_async_pending", {24'd0, pending_out}, 32'h00);
        check("t6_async_busy", {31'd0, busy}, 32'd0);
        check("t6_async_code", {29'd0, code_out}, 32'd0);
        step();
        reset_n    = 1'b1;
        code_ready = 1'b1;
        req_in     = 8'h82;
        step();
        check("t6_ptr_reset_code1", {29'd0, code_out}, 32'd1);
        req_in = 8'h00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
